fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RISC-V core, replacing the bare PC register and next-PC mux in front of decode. It generates sequential fetch addresses into a fixed-latency instruction memory and buffers returned instructions with their PC and PC+4 in a DEPTH-entry FIFO. Decode consumes from the FIFO through a valid/ready handshake. Branch/jump redirects flush the queue and discard the in-flight response.

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end. Issues sequential fetch addresses into a
// fixed-latency (one cycle) instruction memory and buffers each returned
// instruction with its PC and PC+4 in a DEPTH-entry FIFO read by decode.
// A redirect (taken branch/jump) reloads the fetch PC, empties the FIFO and
// drops the response arriving in that cycle.
//
// Ports
//   clk            in   clock, all state on rising edge
//   rst            in   asynchronous active-high reset
//   imem_req       out  fetch request this cycle
//   imem_addr      out  fetch address (word aligned)
//   imem_rdata     in   instruction for the request issued last cycle
//   redirect_valid in   redirect fetch this cycle
//   redirect_pc    in   redirect target, bits [1:0] ignored
//   instr_valid    out  FIFO head valid
//   instr_ready    in   decode accepts head
//   instr          out  head instruction
//   instr_pc       out  head PC
//   instr_pc4      out  head PC+4
//   fq_count       out  FIFO occupancy
//
// Handshake: a head entry transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_valid never depends on instr_ready, and the
// head stays stable until it transfers or a redirect/reset discards it.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      imem_req,
   output logic [XLEN-1:0]           imem_addr,
   input  logic [31:0]               imem_rdata,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [31:0]               instr,
   output logic [XLEN-1:0]           instr_pc,
   output logic [XLEN-1:0]           instr_pc4,
   output logic [$clog2(DEPTH):0]    fq_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   // Architectural state
   logic [XLEN-1:0] r_fetch_pc;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic            r_inflight;
   logic [XLEN-1:0] r_rsp_pc;

   // FIFO storage (no reset needed: entries are only read when counted valid)
   logic [31:0]     r_instr_q [DEPTH];
   logic [XLEN-1:0] r_pc_q    [DEPTH];
   logic [XLEN-1:0] r_pc4_q   [DEPTH];

   logic [CW:0]     w_occ;
   logic            w_issue;
   logic            w_push;
   logic            w_pop;
   logic [XLEN-1:0] w_redirect_pc;

   // Occupancy counts the in-flight slot so a returning response always has
   // room. Only registered state is used: a pop this cycle grants no credit.
   assign w_occ         = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue       = !rst && !redirect_valid && (w_occ < DEPTH_C);
   assign w_push        = r_inflight && !redirect_valid;
   assign w_pop         = instr_valid && instr_ready;
   assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};

   assign imem_req    = w_issue;
   assign imem_addr   = r_fetch_pc;
   assign instr_valid = (r_count != '0);
   assign instr       = r_instr_q[r_rd_ptr];
   assign instr_pc    = r_pc_q[r_rd_ptr];
   assign instr_pc4   = r_pc4_q[r_rd_ptr];
   assign fq_count    = r_count;

   // Control state. Redirect has priority over everything except reset; a pop
   // in the redirect cycle is still a completed transfer, but since the whole
   // queue is discarded its pointer update is irrelevant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
         r_rsp_pc   <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= w_redirect_pc;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
      end else begin
         if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
            r_rsp_pc   <= r_fetch_pc;
         end
         r_inflight <= w_issue;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Response capture into the FIFO slot at the write pointer
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_q[r_wr_ptr] <= imem_rdata;
         r_pc_q[r_wr_ptr]    <= r_rsp_pc;
         r_pc4_q[r_wr_ptr]   <= r_rsp_pc + XLEN'(4);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Bench for fetch_queue (XLEN=32, DEPTH=4, RESET_PC=0x100). The memory model
// answers each request one cycle later with (address ^ MAGIC). A scoreboard
// queue holds the PC stream expected from the current fetch origin (reset or
// redirect target); every pop handshake is compared against its head.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

   logic              clk;
   logic              rst;
   logic              imem_req;
   logic [XLEN-1:0]   imem_addr;
   logic [31:0]       imem_rdata;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [XLEN-1:0]   instr_pc;
   logic [XLEN-1:0]   instr_pc4;
   logic [2:0]        fq_count;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   int hits_40 = 0;

   logic [31:0] exp_q[$];

   fetch_queue #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pc4      (instr_pc4),
      .fq_count       (fq_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   // ---------------- memory model ----------------
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= imem_addr ^ MAGIC;
      else          imem_rdata <= 32'hDEAD_BEEF;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic refill(input logic [31:0] base);
      exp_q.delete();
      for (int k = 0; k < 256; k++) exp_q.push_back(base + 32'(4 * k));
   endtask

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      check("fq_bound", {31'b0, (fq_count > 3'(DEPTH))}, 32'd0);
      if (!rst && instr_valid && instr_ready) begin
         check("sb_empty", {31'b0, (exp_q.size() == 0)}, 32'd0);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pop_pc", instr_pc, e);
            check("pop_pc4", instr_pc4, e + 32'd4);
            check("pop_instr", instr, e ^ MAGIC);
            pops++;
            if (instr_pc == 32'h40) hits_40++;
         end
      end
      if (rst)                 refill(RESET_PC);
      else if (redirect_valid) refill({redirect_pc[31:2], 2'b00});
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int p0;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_cnt", {29'b0, fq_count}, 32'd0);
      step();
      rst = 1'b0;

      // Sequential fetch from RESET_PC, valid two cycles after first request
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("seq_req", {31'b0, imem_req}, 32'd1);
         check("seq_addr", imem_addr, RESET_PC + 32'(4 * k));
         check("seq_valid", {31'b0, instr_valid}, {31'b0, (k >= 2)});
         step();
      end

      // Stall: redirect to 0 with ready low, fill exactly DEPTH entries
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b0;
      @(negedge clk);
      check("rdr_noreq", {31'b0, imem_req}, 32'd0);
      step();
      redirect_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("fill_req", {31'b0, imem_req}, 32'd1);
         check("fill_addr", imem_addr, 32'(4 * k));
         step();
      end
      repeat (4) begin
         @(negedge clk);
         check("full_noreq", {31'b0, imem_req}, 32'd0);
         step();
      end
      @(negedge clk);
      check("full_cnt", {29'b0, fq_count}, 32'd4);
      check("full_valid", {31'b0, instr_valid}, 32'd1);
      step();
      instr_ready = 1'b1;
      @(negedge clk);
      check("no_pop_credit", {31'b0, imem_req}, 32'd0);
      step();
      @(negedge clk);
      check("resume_req", {31'b0, imem_req}, 32'd1);
      check("resume_addr", imem_addr, 32'h10);
      repeat (4) step();

      // Redirect with FIFO holding 3 and a response in flight
      instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (fq_count == 3'd3) break;
         step();
      end
      check("fill3", {29'b0, fq_count}, 32'd3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      @(negedge clk);
      check("rdr2_noreq", {31'b0, imem_req}, 32'd0);
      step();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      @(negedge clk);
      check("rdr2_cnt", {29'b0, fq_count}, 32'd0);
      check("rdr2_valid", {31'b0, instr_valid}, 32'd0);
      check("rdr2_req", {31'b0, imem_req}, 32'd1);
      check("rdr2_addr", imem_addr, 32'h200);
      step();
      @(negedge clk);
      check("rdr2_valid_r2", {31'b0, instr_valid}, 32'd0);
      step();
      @(negedge clk);
      check("rdr2_valid_r3", {31'b0, instr_valid}, 32'd1);
      check("rdr2_first_pc", instr_pc, 32'h200);
      step();

      // Redirect in the same cycle as a pop of head 0x40
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      instr_ready    = 1'b0;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (fq_count >= 3'd2) break;
         step();
      end
      check("fill2", {31'b0, (fq_count >= 3'd2)}, 32'd1);
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      @(negedge clk);
      check("rdr3_head_valid", {31'b0, instr_valid}, 32'd1);
      check("rdr3_head_pc", instr_pc, 32'h40);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("rdr3_valid", {31'b0, instr_valid}, 32'd0);
      check("rdr3_cnt", {29'b0, fq_count}, 32'd0);
      step();

      // Random back-pressure: pointer wrap, ordered +4 stream
      p0 = pops;
      repeat (80) begin
         instr_ready = 1'($urandom_range(0, 1));
         step();
      end
      instr_ready = 1'b1;
      check("rand_pops", {31'b0, ((pops - p0) >= 20)}, 32'd1);
      repeat (4) step();

      // Reset mid-stream while a response is in flight
      rst = 1'b1;
      @(negedge clk);
      check("mrst_req", {31'b0, imem_req}, 32'd0);
      check("mrst_valid", {31'b0, instr_valid}, 32'd0);
      check("mrst_cnt", {29'b0, fq_count}, 32'd0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mrst_addr", imem_addr, RESET_PC + 32'(4 * k));
         check("mrst_seq_valid", {31'b0, instr_valid}, {31'b0, (k >= 2)});
         step();
      end
      @(negedge clk);
      check("mrst_pc", instr_pc, RESET_PC + 32'd4);
      repeat (5) step();

      check("hits_40", 32'(hits_40), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
